// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for irq_ctrl: register offsets, id width, MTIMECMP reset value
// and the address decode / priority helpers.
package irq_ctrl_pkg;

  localparam int unsigned IdW = 5;

  localparam logic [7:0] OffPending = 8'h00;
  localparam logic [7:0] OffEnable  = 8'h04;
  localparam logic [7:0] OffEdge    = 8'h08;
  localparam logic [7:0] OffClaim   = 8'h0C;
  localparam logic [7:0] OffMtimeLo = 8'h10;
  localparam logic [7:0] OffMtimeHi = 8'h14;
  localparam logic [7:0] OffCmpLo   = 8'h18;
  localparam logic [7:0] OffCmpHi   = 8'h1C;

  localparam logic [63:0] MtimecmpRst = {64{1'b1}};

  typedef logic [IdW-1:0] irq_id_t;

  typedef enum logic [2:0] {
    RegPending,
    RegEnable,
    RegEdge,
    RegClaim,
    RegMtimeLo,
    RegMtimeHi,
    RegCmpLo,
    RegCmpHi
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } reg_dec_t;

  // Word address in, so the ignored byte-lane bits never reach the decoder.
  function automatic reg_dec_t reg_decode(input logic [5:0] waddr);
    reg_dec_t d;
    d.hit = 1'b1;
    d.sel = RegPending;
    unique case ({waddr, 2'b00})
      OffPending: d.sel = RegPending;
      OffEnable:  d.sel = RegEnable;
      OffEdge:    d.sel = RegEdge;
      OffClaim:   d.sel = RegClaim;
      OffMtimeLo: d.sel = RegMtimeLo;
      OffMtimeHi: d.sel = RegMtimeHi;
      OffCmpLo:   d.sel = RegCmpLo;
      OffCmpHi:   d.sel = RegCmpHi;
      default:    d.hit = 1'b0;
    endcase
    return d;
  endfunction

  // Returns index+1 of the lowest set bit, 0 when none is set.
  function automatic irq_id_t first_set(input logic [30:0] vec);
    irq_id_t id;
    id = '0;
    for (int i = 30; i >= 0; i--) begin
      if (vec[i]) id = irq_id_t'(i + 1);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Register access bus of irq_ctrl: strobe, direction, address, write and read data.
interface irq_ctrl_if;
  logic        reg_en;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_en, reg_we, reg_addr, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_en, reg_we, reg_addr, reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/irq_timer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp and registered compare interrupt.
// Only instantiated when IRQ_CTRL_TIMER_EN is defined.
module irq_timer
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_mtime_lo_i,
  input  logic        wr_mtime_hi_i,
  input  logic        wr_cmp_lo_i,
  input  logic        wr_cmp_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        timer_irq_o
);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q;
  logic        tick;

  assign tick = (presc_q == 16'(TIMER_DIV - 1));

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A software write to either half takes precedence over this cycle's tick.
    if (wr_mtime_lo_i) mtime_d = {mtime_q[63:32], wdata_i};
    if (wr_mtime_hi_i) mtime_d = {wdata_i, mtime_q[31:0]};
    cmp_d = cmp_q;
    if (wr_cmp_lo_i) cmp_d[31:0] = wdata_i;
    if (wr_cmp_hi_i) cmp_d[63:32] = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      mtime_q <= '0;
      cmp_q   <= MtimecmpRst;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign mtime_o     = mtime_q;
  assign mtimecmp_o  = cmp_q;
  assign timer_irq_o = irq_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level sources, fixed priority, claim/complete handshake.
// Define IRQ_CTRL_TIMER_EN to build the machine timer (irq_timer).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 8,
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  irq_ctrl_if.slave          bus,
  output logic               int_req,
  output irq_id_t            int_id,
  output logic               timer_irq
);

  logic [NUM_SRC-1:0] src_q, src_qq, rise;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] active, svc_mask;
  logic               busy_q, busy_d;
  irq_id_t            isr_id_q, isr_id_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        tmr_rdata;
  reg_dec_t           dec;
  logic               rd_any, wr, claim_fire, complete_fire;
  irq_id_t            win_id;
  logic               unused_bits;

  assign unused_bits = ^{bus.reg_addr[1:0], bus.reg_wdata, 16'(TIMER_DIV)};

  assign dec    = reg_decode(bus.reg_addr[7:2]);
  assign rd_any = bus.reg_en & ~bus.reg_we;
  assign wr     = bus.reg_en & bus.reg_we & dec.hit;

  assign rise    = src_q & ~src_qq;
  assign active  = pending_q & enable_q;
  assign win_id  = first_set(31'(active));
  assign int_req = (|active) & ~busy_q;
  assign int_id  = win_id;

  assign claim_fire    = rd_any && dec.hit && (dec.sel == RegClaim) && !busy_q
                         && (win_id != '0);
  assign complete_fire = wr && (dec.sel == RegClaim) && busy_q
                         && (bus.reg_wdata[IdW-1:0] == isr_id_q);

  // Edge sources: a rise coinciding with their own claim keeps the bit set.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      svc_mask[i] = busy_q && (isr_id_q == irq_id_t'(i + 1));
      if (edge_q[i]) begin
        pending_d[i] = rise[i]
                       | (pending_q[i] & ~(claim_fire && (win_id == irq_id_t'(i + 1))));
      end else begin
        pending_d[i] = src_q[i] & ~svc_mask[i];
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    busy_d   = busy_q;
    isr_id_d = isr_id_q;
    if (wr && (dec.sel == RegEnable)) enable_d = bus.reg_wdata[NUM_SRC-1:0];
    if (wr && (dec.sel == RegEdge))   edge_d   = bus.reg_wdata[NUM_SRC-1:0];
    if (claim_fire) begin
      busy_d   = 1'b1;
      isr_id_d = win_id;
    end else if (complete_fire) begin
      busy_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_any) begin
      rdata_d = '0;
      if (dec.hit) begin
        unique case (dec.sel)
          RegPending: rdata_d = 32'(pending_q);
          RegEnable:  rdata_d = 32'(enable_q);
          RegEdge:    rdata_d = 32'(edge_q);
          RegClaim:   rdata_d = claim_fire ? 32'(win_id) : 32'd0;
          RegMtimeLo, RegMtimeHi, RegCmpLo, RegCmpHi: rdata_d = tmr_rdata;
        endcase
      end
    end
  end

`ifdef IRQ_CTRL_TIMER_EN
  logic [63:0] mtime, mtimecmp;

  irq_timer #(
    .TIMER_DIV(TIMER_DIV)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_mtime_lo_i(wr && (dec.sel == RegMtimeLo)),
    .wr_mtime_hi_i(wr && (dec.sel == RegMtimeHi)),
    .wr_cmp_lo_i  (wr && (dec.sel == RegCmpLo)),
    .wr_cmp_hi_i  (wr && (dec.sel == RegCmpHi)),
    .wdata_i      (bus.reg_wdata),
    .mtime_o      (mtime),
    .mtimecmp_o   (mtimecmp),
    .timer_irq_o  (timer_irq)
  );

  always_comb begin
    tmr_rdata = '0;
    case (dec.sel)
      RegMtimeLo: tmr_rdata = mtime[31:0];
      RegMtimeHi: tmr_rdata = mtime[63:32];
      RegCmpLo:   tmr_rdata = mtimecmp[31:0];
      RegCmpHi:   tmr_rdata = mtimecmp[63:32];
      default:    tmr_rdata = '0;
    endcase
  end
`else
  assign tmr_rdata = '0;
  assign timer_irq = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      src_qq    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      busy_q    <= 1'b0;
      isr_id_q  <= '0;
      rdata_q   <= '0;
    end else begin
      src_q     <= src_i;
      src_qq    <= src_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      busy_q    <= busy_d;
      isr_id_q  <= isr_id_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.reg_rdata = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl; register reads are scored through an expectation queue.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  src = '0;
  logic        int_req;
  logic [4:0]  int_id;
  logic        timer_irq;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp;

`ifdef IRQ_CTRL_TIMER_EN
  localparam logic [31:0] CmpRstHalf = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CmpRstHalf = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .NUM_SRC  (8),
    .TIMER_DIV(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_i    (src),
    .bus      (bus),
    .int_req  (int_req),
    .int_id   (int_id),
    .timer_irq(timer_irq)
  );

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    bus.reg_en = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = addr; bus.reg_wdata = data;
    @(posedge clk);
    #1;
    bus.reg_en = 1'b0; bus.reg_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    bus.reg_en = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = addr;
    @(posedge clk);
    #1;
    bus.reg_en = 1'b0;
    data = bus.reg_rdata;
  endtask

  task automatic test_reset;
    bus.reg_en = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    src = '0; rst_n = 1'b0;
    #12;
    total++;
    if ({int_req, int_id, timer_irq} !== 7'b0 || bus.reg_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs req=%b id=%0d tmr=%b rdata=%h required all zero",
               int_req, int_id, timer_irq, bus.reg_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    exp_q.push_back(32'h0);
    bus_read(8'h00, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_pending got=%h exp=%h", got, exp); end
    exp_q.push_back(CmpRstHalf);
    bus_read(8'h1C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL reset_cmp_hi got=%h exp=%h", got, exp); end
  endtask

  task automatic test_regs;
    bus_write(8'h04, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    bus_read(8'h04, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL enable_width got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0000_00FF);
    bus_read(8'h07, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL addr_lsb_ignored got=%h exp=%h", got, exp); end
    bus_write(8'h20, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    bus_read(8'h20, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL unmapped_read got=%h exp=%h", got, exp); end
    bus_write(8'h08, 32'h0000_01A5);
    exp_q.push_back(32'h0000_00A5);
    bus_read(8'h08, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL edge_reg got=%h exp=%h", got, exp); end
    cycles(3);
    total++;
    if (bus.reg_rdata !== 32'h0000_00A5) begin
      bad++; $display("FAIL rdata_hold got=%h exp=%h", bus.reg_rdata, 32'h0000_00A5);
    end
    bus_write(8'h04, 32'h0);
  endtask

  task automatic test_edge;
    bus_write(8'h04, 32'h0C);
    bus_write(8'h08, 32'h0C);
    src[3] = 1'b1;
    @(posedge clk);
    #1;
    src[3] = 1'b0;
    cycles(2);
    total++;
    if ({int_req, int_id} !== {1'b1, 5'd4}) begin
      bad++; $display("FAIL edge_req req=%b id=%0d required req=1 id=4", int_req, int_id);
    end
    exp_q.push_back(32'd4);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL edge_claim got=%h exp=%h", got, exp); end
    total++;
    if ({int_req, int_id} !== 6'b0) begin
      bad++; $display("FAIL edge_after_claim req=%b id=%0d required 0/0", int_req, int_id);
    end
    exp_q.push_back(32'd0);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL claim_while_busy got=%h exp=%h", got, exp); end
    bus_write(8'h0C, 32'd4);
    src[2] = 1'b1;
    cycles(1);
    src[2] = 1'b0;
    cycles(2);
    total++;
    if ({int_req, int_id} !== {1'b1, 5'd3}) begin
      bad++; $display("FAIL edge_after_complete req=%b id=%0d required req=1 id=3", int_req, int_id);
    end
    exp_q.push_back(32'd3);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL edge_claim3 got=%h exp=%h", got, exp); end
    bus_write(8'h0C, 32'd3);
  endtask

  task automatic test_priority;
    bus_write(8'h04, 32'h24);
    bus_write(8'h08, 32'h2C);
    src = 8'h24;
    cycles(3);
    total++;
    if ({int_req, int_id} !== {1'b1, 5'd3}) begin
      bad++; $display("FAIL prio_first req=%b id=%0d required req=1 id=3", int_req, int_id);
    end
    exp_q.push_back(32'd3);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL prio_claim3 got=%h exp=%h", got, exp); end
    total++;
    if ({int_req, int_id} !== {1'b0, 5'd6}) begin
      bad++; $display("FAIL prio_busy req=%b id=%0d required req=0 id=6", int_req, int_id);
    end
    bus_write(8'h0C, 32'd3);
    total++;
    if ({int_req, int_id} !== {1'b1, 5'd6}) begin
      bad++; $display("FAIL prio_second req=%b id=%0d required req=1 id=6", int_req, int_id);
    end
    exp_q.push_back(32'd6);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL prio_claim6 got=%h exp=%h", got, exp); end
    bus_write(8'h0C, 32'd6);
    src = '0;
    cycles(2);
    total++;
    if ({int_req, int_id} !== 6'b0) begin
      bad++; $display("FAIL prio_idle req=%b id=%0d required 0/0", int_req, int_id);
    end
  endtask

  task automatic test_level;
    bus_write(8'h08, 32'h0);
    bus_write(8'h04, 32'h01);
    src = 8'h01;
    cycles(3);
    total++;
    if ({int_req, int_id} !== {1'b1, 5'd1}) begin
      bad++; $display("FAIL level_req req=%b id=%0d required req=1 id=1", int_req, int_id);
    end
    exp_q.push_back(32'd1);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL level_claim got=%h exp=%h", got, exp); end
    bus_write(8'h0C, 32'd2);
    cycles(2);
    total++;
    if (int_req !== 1'b0) begin
      bad++; $display("FAIL level_wrong_complete req=%b required 0", int_req);
    end
    exp_q.push_back(32'd0);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL level_still_busy got=%h exp=%h", got, exp); end
    bus_write(8'h0C, 32'd1);
    cycles(2);
    total++;
    if ({int_req, int_id} !== {1'b1, 5'd1}) begin
      bad++; $display("FAIL level_reassert req=%b id=%0d required req=1 id=1", int_req, int_id);
    end
    exp_q.push_back(32'd1);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL level_reclaim got=%h exp=%h", got, exp); end
    src = '0;
    cycles(3);
    bus_write(8'h0C, 32'd1);
    cycles(2);
    total++;
    if (int_req !== 1'b0) begin bad++; $display("FAIL level_idle req=%b required 0", int_req); end
  endtask

  task automatic test_collision;
    bus_write(8'h08, 32'h08);
    bus_write(8'h04, 32'h08);
    src[3] = 1'b1;
    cycles(1);
    src[3] = 1'b0;
    cycles(3);
    // Raise again so the rise is visible exactly on the claim edge.
    src[3] = 1'b1;
    cycles(1);
    src[3] = 1'b0;
    exp_q.push_back(32'd4);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL coll_claim got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h08);
    bus_read(8'h00, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL coll_pending got=%h exp=%h", got, exp); end
    bus_write(8'h0C, 32'd4);
    total++;
    if ({int_req, int_id} !== {1'b1, 5'd4}) begin
      bad++; $display("FAIL coll_rerequest req=%b id=%0d required req=1 id=4", int_req, int_id);
    end
    exp_q.push_back(32'd4);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL coll_claim2 got=%h exp=%h", got, exp); end
    bus_write(8'h0C, 32'd4);
  endtask

  task automatic test_timer;
`ifdef IRQ_CTRL_TIMER_EN
    bus_write(8'h18, 32'h10);
    bus_write(8'h1C, 32'h0);
    bus_write(8'h14, 32'h0);
    bus_write(8'h10, 32'h0);
    cycles(16);
    total++;
    if (timer_irq !== 1'b0) begin bad++; $display("FAIL timer_early irq=%b required 0", timer_irq); end
    cycles(1);
    total++;
    if (timer_irq !== 1'b1) begin bad++; $display("FAIL timer_fire irq=%b required 1", timer_irq); end
    exp_q.push_back(32'd17);
    bus_read(8'h10, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL mtime_lo got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h10);
    bus_read(8'h18, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL mtimecmp_lo got=%h exp=%h", got, exp); end
    bus_write(8'h10, 32'h0);
    cycles(1);
    total++;
    if (timer_irq !== 1'b0) begin bad++; $display("FAIL timer_clear irq=%b required 0", timer_irq); end
`else
    bus_write(8'h10, 32'h1234);
    bus_write(8'h18, 32'h5);
    exp_q.push_back(32'h0);
    bus_read(8'h10, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL notimer_mtime got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(8'h18, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL notimer_cmp got=%h exp=%h", got, exp); end
    total++;
    if (timer_irq !== 1'b0) begin bad++; $display("FAIL notimer_irq irq=%b required 0", timer_irq); end
`endif
  endtask

  task automatic test_reset_mid_claim;
    bus_write(8'h08, 32'h0);
    bus_write(8'h04, 32'h01);
    src = 8'h01;
    cycles(3);
    exp_q.push_back(32'd1);
    bus_read(8'h0C, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL rst_claim got=%h exp=%h", got, exp); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({int_req, int_id, timer_irq} !== 7'b0 || bus.reg_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_async req=%b id=%0d tmr=%b rdata=%h required all zero",
               int_req, int_id, timer_irq, bus.reg_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    exp_q.push_back(CmpRstHalf);
    bus_read(8'h18, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL rst_cmp_lo got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(8'h04, got); exp = exp_q.pop_front(); total++;
    if (got !== exp) begin bad++; $display("FAIL rst_enable got=%h exp=%h", got, exp); end
    total++;
    if (int_req !== 1'b0) begin bad++; $display("FAIL rst_no_req req=%b required 0", int_req); end
    src = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_regs();
    test_edge();
    test_priority();
    test_level();
    test_collision();
    test_timer();
    test_reset_mid_claim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
